// File: rtl/gs_div_pkg.sv
// Shared widths and reciprocal table for the Goldschmidt divider datapath.
// Latency: n/a (constants and an elaboration-time table function only).
// Backpressure: n/a.
package gs_div_pkg;

  localparam int W_OP   = 64;  // Q32.32 operand width (N, D)
  localparam int W_F    = 33;  // Q1.32 factor width
  localparam int W_P    = 97;  // full product width W_OP + W_F
  localparam int W_FRAC = 32;  // fraction bits of every fixed-point value

  // R[m] = floor(2^17 / (513 + 2m)).
  // The divisor is the midpoint of mantissa bucket m (scaled by 512), so every
  // entry lands in 128..255 and fits 8 bits.
  function automatic logic [7:0] recip_lut(input logic [7:0] m);
    return 8'(18'd131072 / (18'd513 + {9'd0, m, 1'b0}));
  endfunction

endpackage

// File: rtl/first_guess.sv
// Reciprocal seed: maps the integer part of the divisor to a Q0.32 estimate of 1/D.
// Latency: purely combinational.
// Backpressure: none; the output follows d_hi continuously.
module first_guess
  import gs_div_pkg::*;
(
  input  logic [31:0] d_hi,
  output logic [31:0] seed
);

  // Table is built from constant function calls, so it elaborates to a ROM.
  logic [7:0] lut [256];

  for (genvar i = 0; i < 256; i++) begin : g_lut
    assign lut[i] = recip_lut(8'(i));
  end

  logic [4:0] k;  // index of leading one
  logic [7:0] m;  // 8 mantissa bits below the leading one
  logic [7:0] r;  // table reciprocal of the normalised mantissa

  // Normalise d_hi, look up the mantissa reciprocal and scale back by 2^-k.
  always_comb begin
    k = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (d_hi[i]) k = 5'(i);
    end
    m = 8'((d_hi << (5'd31 - k)) >> 23);
    r = lut[m];
    if (d_hi == 32'd0) begin
      // Divide-by-zero saturates to the largest representable seed.
      seed = 32'hFFFF_FFFF;
    end else if (k <= 5'd24) begin
      seed = {24'd0, r} << (5'd24 - k);
    end else begin
      seed = {24'd0, r} >> (k - 5'd24);
    end
  end

endmodule

// File: rtl/first_guess_mult.sv
// Goldschmidt datapath step: seed lookup plus two registered 64x33 multiplies (N*F, D*F).
// Latency: 1 cycle from in_valid to out_valid; derived outputs are combinational from the registers.
// Backpressure: none; every in_valid cycle is accepted, idle cycles hold the registers.
module first_guess_mult
  import gs_div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              seed_sel,
  input  logic [31:0]       d_hi,
  input  logic [W_OP-1:0]   a0,
  input  logic [W_OP-1:0]   a1,
  input  logic [W_F-1:0]    b,
  output logic [W_F-1:0]    f_seed,
  output logic [W_P-1:0]    c0,
  output logic [W_P-1:0]    c1,
  output logic [W_OP-1:0]   n_next,
  output logic [W_OP-1:0]   d_next,
  output logic [W_F-1:0]    f_next,
  output logic              out_valid
);

  logic [31:0]    seed;
  logic [W_F-1:0] fsel;

  first_guess u_first_guess (
    .d_hi (d_hi),
    .seed (seed)
  );

  // The first step multiplies by the seed; later steps use the fed-back 2-D factor.
  always_comb begin
    fsel = seed_sel ? {1'b0, seed} : b;
  end

  // Register both full-width products and the seed; idle cycles keep the last results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      c0        <= '0;
      c1        <= '0;
      f_seed    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c0     <= W_P'(a0) * W_P'(fsel);
        c1     <= W_P'(a1) * W_P'(fsel);
        f_seed <= {1'b0, seed};
      end
    end
  end

  // Rescale Q33.64 products back to Q32.32; next factor is the two's complement
  // of D truncated to Q1.32, which equals 2 - D while D is near 1.
  always_comb begin
    n_next = c0[W_FRAC+W_OP-1:W_FRAC];
    d_next = c1[W_FRAC+W_OP-1:W_FRAC];
    f_next = ~c1[W_FRAC+W_F-1:W_FRAC] + 33'd1;
  end

endmodule

// File: tb/tb_first_guess_mult.sv
// Self-checking bench: per-cycle behavioural model plus literal and end-to-end division checks.
// Latency: model expects results one clock after each in_valid cycle.
// Backpressure: none exercised; DUT accepts every valid cycle.
module tb_first_guess_mult;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         seed_sel = 1'b0;
  logic [31:0]  d_hi = '0;
  logic [63:0]  a0 = '0;
  logic [63:0]  a1 = '0;
  logic [32:0]  b = '0;
  logic [32:0]  f_seed;
  logic [96:0]  c0;
  logic [96:0]  c1;
  logic [63:0]  n_next;
  logic [63:0]  d_next;
  logic [32:0]  f_next;
  logic         out_valid;

  int vecs = 0;
  int errs = 0;

  first_guess_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .seed_sel  (seed_sel),
    .d_hi      (d_hi),
    .a0        (a0),
    .a1        (a1),
    .b         (b),
    .f_seed    (f_seed),
    .c0        (c0),
    .c1        (c1),
    .n_next    (n_next),
    .d_next    (d_next),
    .f_next    (f_next),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Seed from the arithmetic definition: scale d into [1,2), take 8 mantissa
  // bits, divide into 2^17, scale back by 2^-k.
  function automatic logic [31:0] model_seed(input logic [31:0] d);
    longint unsigned dl, m, r, s;
    int k;
    if (d == 0) return 32'hFFFF_FFFF;
    dl = longint'(d);
    k  = $clog2(dl + 1) - 1;
    m  = ((dl * (64'd1 << (31 - k))) / 64'd8388608) % 256;
    r  = 131072 / (513 + 2 * m);
    if (k <= 24) s = r * (64'd1 << (24 - k));
    else         s = r / (64'd1 << (k - 24));
    return 32'(s);
  endfunction

  // Behavioural model of the registered state.
  logic        m_vld  = 1'b0;
  logic [96:0] m_c0   = '0;
  logic [96:0] m_c1   = '0;
  logic [32:0] m_seed = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld  <= 1'b0;
      m_c0   <= '0;
      m_c1   <= '0;
      m_seed <= '0;
    end else begin
      m_vld <= in_valid;
      if (in_valid) begin
        m_c0   <= {33'd0, a0} * {64'd0, (seed_sel ? {1'b0, model_seed(d_hi)} : b)};
        m_c1   <= {33'd0, a1} * {64'd0, (seed_sel ? {1'b0, model_seed(d_hi)} : b)};
        m_seed <= {1'b0, model_seed(d_hi)};
      end
    end
  end

  // Compare every output against the model on each falling edge.
  logic [33:0] two_minus_d;
  always @(negedge clk) begin
    two_minus_d = 34'h2_0000_0000 - {1'b0, m_c1[64:32]};
    check("out_valid", out_valid, m_vld);
    check("f_seed", f_seed, m_seed);
    check("c0", c0, m_c0);
    check("c1", c1, m_c1);
    check("n_next", n_next, m_c0[95:32]);
    check("d_next", d_next, m_c1[95:32]);
    check("f_next", f_next, two_minus_d[32:0]);
  end

  task automatic apply(input logic iv, input logic ss, input logic [31:0] dh,
                       input logic [63:0] x0, input logic [63:0] x1, input logic [32:0] fb);
    in_valid = iv;
    seed_sel = ss;
    d_hi     = dh;
    a0       = x0;
    a1       = x1;
    b        = fb;
    @(posedge clk);
    #1;
  endtask

  // One seed step then four refinement steps, feeding results back.
  task automatic divide(input logic [31:0] n, input logic [31:0] d, output logic [31:0] q,
                        output logic [63:0] dfin);
    apply(1'b1, 1'b1, d, {n, 32'd0}, {d, 32'd0}, 33'd0);
    for (int s = 0; s < 4; s++) begin
      apply(1'b1, 1'b0, $urandom, n_next, d_next, f_next);
    end
    q    = n_next[63:32];
    dfin = d_next;
  endtask

  initial begin
    logic [31:0] q;
    logic [63:0] dfin;
    logic [31:0] n, d, qg;
    logic        ok;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_c0", c0, 97'd0);
    check("rst_c1", c1, 97'd0);
    check("rst_f_seed", f_seed, 33'd0);
    check("rst_f_next", f_next, 33'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Seed literals.
    apply(1'b1, 1'b1, 32'd0, 64'd0, 64'd0, 33'd0);
    check("seed_d0", f_seed, 33'h0_FFFF_FFFF);
    apply(1'b1, 1'b1, 32'd1, 64'd0, 64'd0, 33'd0);
    check("seed_d1", f_seed, 33'h0_FF00_0000);
    apply(1'b1, 1'b1, 32'd3, 64'd0, 64'd0, 33'd0);
    check("seed_d3", f_seed, 33'h0_5500_0000);

    // Unity factor.
    apply(1'b1, 1'b0, 32'd3, 64'h1234, 64'h0000_0000_FFFF_0000, 33'h1_0000_0000);
    check("unity_d_next", d_next, 64'h0000_0000_FFFF_0000);
    check("unity_f_next", f_next, 33'h1_0001_0000);
    check("unity_out_valid", out_valid, 1'b1);

    // Max operands.
    apply(1'b1, 1'b0, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 33'h1_FFFF_FFFF);
    check("max_c0", c0, 97'h1_FFFF_FFFE_FFFF_FFFE_0000_0001);

    // Hold for three idle cycles with changing inputs.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, $urandom_range(1, 0), $urandom, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom_range(1, 0), $urandom});
      check("hold_out_valid", out_valid, 1'b0);
      check("hold_c0", c0, 97'h1_FFFF_FFFE_FFFF_FFFE_0000_0001);
      check("hold_c1", c1, 97'h9_FFFF_FFFB);
      check("hold_f_seed", f_seed, 33'h0_5500_0000);
    end

    // End-to-end 100 / 7.
    divide(32'd100, 32'd7, q, dfin);
    check("div_100_7", q, 32'd14);

    // Random per-cycle stimulus.
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(3, 0) != 0, $urandom_range(1, 0),
            ($urandom_range(3, 0) == 0) ? 32'($urandom_range(8, 0)) : 32'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom_range(1, 0), $urandom});
    end

    // Asynchronous reset mid-operation.
    apply(1'b1, 1'b0, 32'd9, 64'hDEAD_BEEF_0000_1111, 64'h0000_0007_8000_0000, 33'h1_2345_6789);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_c0", c0, 97'd0);
    check("arst_c1", c1, 97'd0);
    check("arst_f_next", f_next, 33'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random divisions against floor(N/D); an exact quotient may land one low.
    for (int i = 0; i < 2000; i++) begin
      d = 32'($urandom_range(1023, 2));
      n = 32'($urandom_range(65535, 32'(d + 1)));
      divide(n, d, q, dfin);
      qg = n / d;
      ok = (q == qg) || ((n % d == 0) && (q == qg - 1));
      vecs++;
      if (!ok) begin
        errs++;
        $display("FAIL div_rand: %0d/%0d got %0d, expected %0d", n, d, q, qg);
      end
      vecs++;
      if (dfin < 64'h0000_0000_FFFF_0000 || dfin > 64'h0000_0001_0001_0000) begin
        errs++;
        $display("FAIL div_d_conv: %0d/%0d d_next %h, expected near 64'h1_0000_0000", n, d, dfin);
      end
    end

    in_valid = 1'b0;
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
